// File: rtl/mem_req_ctrl_if.sv
// Host command/response and memory strobe bundle for mem_req_ctrl.
// The controller takes the slave view; the host/memory environment takes the master view.
interface mem_req_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata, mem_ack,
    output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata, mem_ack,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// Command FIFO plus single-outstanding access sequencer in front of the 32x8 mem,
// with an ack timeout that turns a silent memory into an error response.
module mem_req_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15,
  parameter int AW      = 5,
  parameter int DW      = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_req_ctrl_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  logic [AW-1:0]    r_fifo_addr  [DEPTH];
  logic [DW-1:0]    r_fifo_wdata [DEPTH];
  logic [DEPTH-1:0] r_fifo_we;
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count, w_count_nxt;
  logic             r_req_ready;
  logic             w_push, w_pop, w_empty;

  state_t           r_state, w_state;
  logic             r_cmd_we, w_cmd_we;
  logic             r_mem_read, w_mem_read;
  logic             r_mem_write, w_mem_write;
  logic [AW-1:0]    r_mem_addr, w_mem_addr;
  logic [DW-1:0]    r_mem_wdata, w_mem_wdata;
  logic [TW-1:0]    r_timer, w_timer;
  logic             r_rsp_valid, w_rsp_valid;
  logic             r_rsp_we, w_rsp_we;
  logic [DW-1:0]    r_rsp_rdata, w_rsp_rdata;
  logic             r_rsp_err, w_rsp_err;

  assign w_empty = (r_count == '0);
  assign w_push  = bus.req_valid && r_req_ready;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr]  <= bus.req_addr;
      r_fifo_wdata[r_wr_ptr] <= bus.req_wdata;
      r_fifo_we[r_wr_ptr]    <= bus.req_we;
    end
  end

  // req_ready is a registered !full, so it is low while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count     <= w_count_nxt;
      r_req_ready <= (w_count_nxt != CW'(DEPTH));
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cmd_we    = r_cmd_we;
    w_mem_read  = r_mem_read;
    w_mem_write = r_mem_write;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_timer     = r_timer;
    w_rsp_valid = r_rsp_valid;
    w_rsp_we    = r_rsp_we;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_err   = r_rsp_err;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state     = S_ISSUE;
          w_cmd_we    = r_fifo_we[r_rd_ptr];
          w_mem_read  = !r_fifo_we[r_rd_ptr];
          w_mem_write = r_fifo_we[r_rd_ptr];
          w_mem_addr  = r_fifo_addr[r_rd_ptr];
          w_mem_wdata = r_fifo_wdata[r_rd_ptr];
          w_timer     = '0;
        end
      end
      S_ISSUE: begin
        // Ack is tested first so it wins over a timeout on the same edge.
        if (bus.mem_ack) begin
          w_state     = S_RESP;
          w_mem_read  = 1'b0;
          w_mem_write = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_we    = r_cmd_we;
          w_rsp_err   = 1'b0;
          w_rsp_rdata = r_cmd_we ? '0 : bus.mem_rdata;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_state     = S_RESP;
          w_mem_read  = 1'b0;
          w_mem_write = 1'b0;
          w_rsp_valid = 1'b1;
          w_rsp_we    = r_cmd_we;
          w_rsp_err   = 1'b1;
          w_rsp_rdata = '0;
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state     = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd_we    <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_timer     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cmd_we    <= w_cmd_we;
      r_mem_read  <= w_mem_read;
      r_mem_write <= w_mem_write;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_timer     <= w_timer;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_we    <= w_rsp_we;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_we    = r_rsp_we;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl: a behavioural 32x8 memory answers strobes
// with a programmable ack delay while a reference array predicts every response.
module tb_mem_req_ctrl;
  localparam int AW = 5;
  localparam int DW = 8;

  typedef struct packed {
    logic          we;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_req_ctrl_if #(.AW(AW), .DW(DW)) bus();

  mem_req_ctrl #(.DEPTH(4), .TIMEOUT(15), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  rsp_t sb[$];
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] sim_mem [32];
  int ack_delay = 1;
  int scnt = 0;
  int last_len = 0;
  int both_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural memory: ack on the ack_delay-th strobe cycle, never if ack_delay==0.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        scnt = 0;
        bus.mem_ack = 1'b0;
      end else if (bus.mem_read || bus.mem_write) begin
        if (bus.mem_read && bus.mem_write) both_seen++;
        scnt++;
        if (ack_delay != 0 && scnt == ack_delay) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_write) begin
            sim_mem[bus.mem_addr] = bus.mem_wdata;
            bus.mem_rdata = 8'hA5;
          end else begin
            bus.mem_rdata = sim_mem[bus.mem_addr];
          end
        end else begin
          bus.mem_ack = 1'b0;
          bus.mem_rdata = 8'hEE;
        end
      end else begin
        if (scnt != 0) last_len = scnt;
        scnt = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 8'hEE;
      end
    end
  end

  // Response monitor: the handshake completes on the following rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_we",    32'(bus.rsp_we),    32'(e.we));
          chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
          chk("rsp_err",   32'(bus.rsp_err),   32'(e.err));
        end
      end
    end
  end

  // Callers are always at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rsp_t e;
    int n;
    bit ok, done;
    e.we = we;
    if (ack_delay == 0 || ack_delay > 15) begin
      e.err = 1'b1;
      e.rdata = '0;
    end else begin
      e.err = 1'b0;
      if (we) begin
        ref_mem[a] = d;
        e.rdata = '0;
      end else begin
        e.rdata = ref_mem[a];
      end
    end
    sb.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      ok = bus.req_ready;
      @(posedge clk);
      #1;
      if (ok) done = 1'b1;
      n++;
    end
    bus.req_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.rsp_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic          h_we, h_err;
    logic [DW-1:0] h_rdata;
    int viol;
    int n;
    for (int i = 0; i < 32; i++) begin
      ref_mem[i] = 8'($urandom);
      sim_mem[i] = ref_mem[i];
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_strobes",   32'({bus.mem_read, bus.mem_write}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // Reset while a read strobe is held by a dead memory.
    ack_delay = 0;
    push(1'b0, 5'd9, 8'h00);
    @(posedge clk);
    #1;
    chk("mid_issue_read", 32'(bus.mem_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_strobes", 32'({bus.mem_read, bus.mem_write}), 32'd0);
    chk("async_rst_rsp",     32'(bus.rsp_valid), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_req_ready", 32'(bus.req_ready), 32'd1);

    // Write 0x5A @3 then read it back, checking push-to-strobe latency.
    ack_delay = 1;
    push(1'b1, 5'd3, 8'h5A);
    chk("lat_no_strobe_yet", 32'(bus.mem_write), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_write_strobe", 32'(bus.mem_write), 32'd1);
    chk("lat_addr",  32'(bus.mem_addr),  32'd3);
    chk("lat_wdata", 32'(bus.mem_wdata), 32'h5A);
    push(1'b0, 5'd3, 8'h00);
    drain();

    // Fill the FIFO behind a stalled response; the sixth push must wait.
    bus.rsp_ready = 1'b0;
    push(1'b1, 5'd10, 8'h11);
    push(1'b0, 5'd10, 8'h00);
    push(1'b1, 5'd20, 8'h22);
    push(1'b0, 5'd20, 8'h00);
    push(1'b0, 5'd3,  8'h00);
    fork
      push(1'b0, 5'd10, 8'h00);
      begin
        repeat (6) @(posedge clk);
        #1;
        chk("full_req_ready", 32'(bus.req_ready), 32'd0);
        chk("full_sb_depth",  32'(sb.size()),     32'd6);
        bus.rsp_ready = 1'b1;
      end
    join
    drain();

    // Dead memory: strobe held exactly 15 cycles then an error response.
    ack_delay = 0;
    push(1'b0, 5'd7, 8'h00);
    drain();
    chk("timeout_len", 32'(last_len), 32'd15);
    ack_delay = 1;
    push(1'b0, 5'd3, 8'h00);
    drain();

    // Ack on the final allowed cycle wins; one cycle later is a timeout.
    ack_delay = 15;
    push(1'b0, 5'd7, 8'h00);
    drain();
    ack_delay = 16;
    push(1'b0, 5'd20, 8'h00);
    drain();

    // Response stall: outputs frozen and no new strobe while a command waits.
    ack_delay = 2;
    bus.rsp_ready = 1'b0;
    push(1'b0, 5'd10, 8'h00);
    push(1'b1, 5'd11, 8'h77);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    h_we = bus.rsp_we;
    h_rdata = bus.rsp_rdata;
    h_err = bus.rsp_err;
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (!bus.rsp_valid || bus.rsp_we !== h_we || bus.rsp_rdata !== h_rdata ||
          bus.rsp_err !== h_err || bus.mem_read || bus.mem_write) viol++;
    end
    chk("stall_stable", 32'(viol), 32'd0);
    bus.rsp_ready = 1'b1;
    drain();
    ack_delay = 1;
    push(1'b0, 5'd11, 8'h00);
    drain();

    chk("strobe_exclusive", 32'(both_seen), 32'd0);
    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
